// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-byte outputs of the UART receive stage
// Signals: rx (serial line, idle high), data_out (last good byte),
//          valid (new-byte strobe), frame_err (bad stop bit strobe), busy (frame in progress).
// master: line driver / byte consumer. slave: the receiver.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  modport master (output rx, input data_out, valid, frame_err, busy);
  modport slave (input rx, output data_out, valid, frame_err, busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver sampling each bit at its midpoint
// Ports: clk (rising-edge clock), rst (sync active-high reset),
//        bus (uart_rx_if.slave: rx in; data_out, valid, frame_err, busy out).
// Optional UART_RX_SYNC_EN: rx goes through a two-flop synchroniser (+2 cycle latency).
module uart_receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);
  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] last_cnt = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] half_cnt = 16'(HALF_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t      state;
  logic [15:0] clk_count;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  data;
  logic        valid;
  logic        frame_err;
  logic        rx_s;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk)
    sync <= rst ? 2'b11 : {sync[0], bus.rx};
  assign rx_s = sync[1];
`else
  assign rx_s = bus.rx;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            // with no half-bit offset the start bit cannot be rechecked, so go straight to data
            state     <= (half_cnt == 16'd0) ? DATA : START;
            clk_count <= (half_cnt == 16'd0) ? 16'd0 : 16'd1;
          end
        START:
          if (clk_count < half_cnt) clk_count <= clk_count + 16'd1;
          else begin
            clk_count <= '0;
            state     <= rx_s ? IDLE : DATA;
          end
        DATA:
          if (clk_count != last_cnt) clk_count <= clk_count + 16'd1;
          else begin
            clk_count      <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        STOP:
          if (clk_count != last_cnt) clk_count <= clk_count + 16'd1;
          else begin
            clk_count <= '0;
            // leaving mid stop bit lets a back-to-back start edge be caught on its first low cycle
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end
        BRK:
          if (rx_s) state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end
  assign bus.data_out  = data;
  assign bus.valid     = valid;
  assign bus.frame_err = frame_err;
  assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed checks of uart_receiver at CLKS_PER_BIT=4 and CLKS_PER_BIT=1
module tb_uart_receiver;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_rx_if ifa ();
  uart_rx_if ifb ();
  uart_receiver #(.CLKS_PER_BIT(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_receiver #(.CLKS_PER_BIT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  int checks = 0;
  int errors = 0;
  logic wave[$];
  int v_cnt, v_first, v_second, fe_cnt, fe_first, busy_hi, busy_first_hi, busy_first_lo;
  int both = 0;
  logic [7:0] v_data, v_data2, fe_data, r_data;
  logic r_valid, r_fe, r_busy;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic add_level(input logic v, input int n);
    repeat (n) wave.push_back(v);
  endtask
  task automatic add_frame(input logic [7:0] d, input logic stop, input int cpb);
    add_level(1'b0, cpb);
    for (int i = 0; i < 8; i++) add_level(d[i], cpb);
    add_level(stop, cpb);
  endtask
  // wave[0] is cycle t0; observations after each edge belong to cycle t0+c
  task automatic play(input bit sel, input int rst_at);
    int c;
    logic [7:0] d;
    logic v, fe, b;
    v_cnt = 0; v_first = -1; v_second = -1; fe_cnt = 0; fe_first = -1;
    busy_hi = 0; busy_first_hi = -1; busy_first_lo = -1;
    v_data = 0; v_data2 = 0; fe_data = 0;
    for (int k = 0; k < wave.size(); k++) begin
      if (sel) ifb.rx = wave[k];
      else ifa.rx = wave[k];
      rst = (k == rst_at);
      tick;
      c  = k + 1;
      d  = sel ? ifb.data_out : ifa.data_out;
      v  = sel ? ifb.valid : ifa.valid;
      fe = sel ? ifb.frame_err : ifa.frame_err;
      b  = sel ? ifb.busy : ifa.busy;
      if (c == rst_at + 1) begin
        r_data = d; r_valid = v; r_fe = fe; r_busy = b;
      end
      if (v) begin
        v_cnt++;
        if (v_cnt == 1) begin v_first = c; v_data = d; end
        else if (v_cnt == 2) begin v_second = c; v_data2 = d; end
      end
      if (fe) begin
        fe_cnt++;
        if (fe_cnt == 1) begin fe_first = c; fe_data = d; end
      end
      if (b) begin
        busy_hi++;
        if (busy_first_hi < 0) busy_first_hi = c;
      end else if (busy_hi > 0 && busy_first_lo < 0) busy_first_lo = c;
      if (v && fe) both++;
    end
    rst = 1'b0;
    ifa.rx = 1'b1;
    ifb.rx = 1'b1;
    wave.delete();
  endtask
  initial begin
    ifa.rx = 1'b1;
    ifb.rx = 1'b1;
    rst = 1'b1;
    repeat (3) tick;
    check("rst_data", ifa.data_out, 8'h00);
    check("rst_valid", ifa.valid, 0);
    check("rst_ferr", ifa.frame_err, 0);
    check("rst_busy", ifa.busy, 0);
    rst = 1'b0;
    repeat (3) tick;
    add_frame(8'hA5, 1'b1, 4);
    add_level(1'b1, 10);
    play(1'b0, -1);
    check("a5_valid_cycle", v_first, 38 + LAT);
    check("a5_valid_count", v_cnt, 1);
    check("a5_data", v_data, 8'hA5);
    check("a5_ferr_count", fe_cnt, 0);
    check("a5_busy_low_cycle", busy_first_lo, 38 + LAT);
    add_frame(8'h3C, 1'b1, 1);
    add_frame(8'hC3, 1'b1, 1);
    add_level(1'b1, 10);
    play(1'b1, -1);
    check("b2b_first_cycle", v_first, 10 + LAT);
    check("b2b_second_cycle", v_second, 20 + LAT);
    check("b2b_data1", v_data, 8'h3C);
    check("b2b_data2", v_data2, 8'hC3);
    check("b2b_valid_count", v_cnt, 2);
    check("b2b_busy_gap", busy_first_lo, 10 + LAT);
    add_level(1'b0, 1);
    add_level(1'b1, 20);
    play(1'b0, -1);
    check("glitch_valid_count", v_cnt, 0);
    check("glitch_ferr_count", fe_cnt, 0);
    check("glitch_busy_cycles", busy_hi, 1);
    check("glitch_busy_start", busy_first_hi, 1 + LAT);
    add_frame(8'hFF, 1'b0, 4);
    add_level(1'b0, 20);
    add_level(1'b1, 5);
    add_frame(8'h55, 1'b1, 4);
    add_level(1'b1, 10);
    play(1'b0, -1);
    check("brk_ferr_cycle", fe_first, 38 + LAT);
    check("brk_ferr_count", fe_cnt, 1);
    check("brk_data_held", fe_data, 8'hA5);
    check("brk_busy_low_cycle", busy_first_lo, 61 + LAT);
    check("brk_next_cycle", v_first, 103 + LAT);
    check("brk_next_data", v_data, 8'h55);
    check("brk_valid_count", v_cnt, 1);
    add_level(1'b0, 4);
    add_level(1'b1, 4);
    add_level(1'b0, 8);
    add_level(1'b1, 20);
    add_frame(8'h42, 1'b1, 4);
    add_level(1'b1, 10);
    play(1'b0, 15);
    check("abort_rst_data", r_data, 8'h00);
    check("abort_rst_valid", r_valid, 0);
    check("abort_rst_ferr", r_fe, 0);
    check("abort_rst_busy", r_busy, 0);
    check("abort_valid_count", v_cnt, 1);
    check("abort_ferr_count", fe_cnt, 0);
    check("abort_next_cycle", v_first, 74 + LAT);
    check("abort_next_data", v_data, 8'h42);
    check("never_both", both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; the downstream consumer of the UART transmit stage's `tx` line (8N1, LSB first, idle high).
- Samples each bit at its midpoint using the same `CLKS_PER_BIT` timing as the transmitter.
- Delivers each byte with a one-cycle `valid` strobe and flags bad stop bits.
- Used in loopback against the sender and as the host-command input path on the board.

Parameters:
- CLKS_PER_BIT, default 1, clock cycles per serial bit; legal range 1..65535.
- HALF_BIT, default (CLKS_PER_BIT-1)/2 (integer division), offset from the start-bit falling edge to the bit midpoint; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line; idle high.
- data_out  output  8  last correctly framed byte; held until the next good byte.
- valid  output  1  one-cycle pulse; data_out is new this cycle.
- frame_err  output  1  one-cycle pulse; the stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: one clock, synchronous and active-high; reset is sampled on `clk` only.
  - State goes to IDLE; bit counter and bit index go to 0; the shift register goes to 0.
  - data_out=8'h00, valid=0, frame_err=0, busy=0.
  - Reset during any state aborts the frame. No valid or frame_err is emitted for the aborted frame.
- Internal registers:
  - 16-bit clk_count.
  - 3-bit bit_idx.
  - 8-bit shift register; bits fill LSB first, so bit_idx n is written to shift[n].
- Let rx_s be the sampled line: rx directly, or the synchronised copy (see Optional Feature).
- IDLE:
  - When rx_s==0 on cycle t0, t0 is the detection cycle.
  - If HALF_BIT==0: go to DATA with clk_count=0 (the start bit is accepted without a recheck).
  - Otherwise: go to START with clk_count=1.
- START:
  - While clk_count<HALF_BIT, increment clk_count.
  - At clk_count==HALF_BIT: if rx_s==0, go to DATA with clk_count=0.
  - If rx_s==1 at that point, treat it as a glitch: return to IDLE with no output pulse.
- DATA:
  - Increment clk_count until clk_count==CLKS_PER_BIT-1.
  - On that cycle: shift[bit_idx]<=rx_s and clk_count<=0.
  - If bit_idx<7, increment bit_idx. Otherwise set bit_idx<=0 and go to STOP.
  - Every sample falls at cycle t0+HALF_BIT+(n+1)*CLKS_PER_BIT, the midpoint of bit n.
- STOP:
  - Count to CLKS_PER_BIT-1, then sample rx_s.
  - Sample 1: data_out<=shift, valid<=1 for one cycle, go to IDLE.
  - Sample 0: frame_err<=1 for one cycle, data_out unchanged, go to BREAK.
- BREAK:
  - Stay until rx_s==1, then go to IDLE.
  - This prevents a held-low line (break) from retriggering continuously.
- Latency: valid or frame_err rises at cycle t0+HALF_BIT+9*CLKS_PER_BIT+1 (registered).
- Back-to-back frames:
  - IDLE is re-entered mid stop bit, so the next start edge is detected on its first low cycle.
  - No gap is required beyond the single stop bit.
- valid and frame_err are never high together. Each is deasserted on the cycle after it pulses.
- A new frame may start while the consumer is still reading data_out; data_out is overwritten only on the next valid.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined:
  - rx passes through a two-flop synchroniser before use; both flops reset to 1.
  - rx_s is the second flop's output, so all timing above shifts by +2 cycles relative to the rx pin.
- Undefined:
  - rx_s=rx with no added latency.
  - This mode is for on-chip loopback from the sender, where rx is already synchronous to clk.

Test Plan:
- CLKS_PER_BIT=4, macro undefined, frame 0xA5 with start bit first low at t0 → valid=1 only at t0+38, data_out=8'hA5, frame_err=0, busy low at t0+38.
- CLKS_PER_BIT=1, loopback from the sender sending 0x3C then 0xC3 back-to-back → two valid pulses 10 cycles apart, data_out 8'h3C then 8'hC3.
- CLKS_PER_BIT=4, rx low for 1 cycle only at t0 → return to IDLE at t0+2, no valid or frame_err, busy high for exactly t0+1..t0+1.
- CLKS_PER_BIT=4, byte 0xFF with stop bit held low and line held low 20 more cycles → frame_err pulse at t0+38, data_out keeps its previous value, busy stays high until rx returns high, then the next 0x55 frame is received correctly.
- Assert rst at t0+15 during a 0x81 frame, release, then send 0x42 → no output for 0x81; valid with 8'h42; all outputs 0 on the cycle after rst.
- UART_RX_SYNC_EN defined, CLKS_PER_BIT=4, frame 0x5A → valid at t0+40 with data_out=8'h5A.
